// File: rtl/fifo_v4.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fifo_v4 : synchronous FIFO, any depth, optional fall-through, sticky err |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module fifo_v4 #(
  parameter int FALL_THROUGH = 0,
  parameter int DATA_WIDTH   = 32,
  parameter int DEPTH        = 8,
  localparam int CNT_W       = $clog2(DEPTH + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  flush_i,
  input  logic                  clr_err_i,
  input  logic [CNT_W-1:0]      almost_full_th_i,
  input  logic [CNT_W-1:0]      almost_empty_th_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  push_i,
  output logic [DATA_WIDTH-1:0] data_o,
  input  logic                  pop_i,
  output logic                  full_o,
  output logic                  empty_o,
  output logic                  almost_full_o,
  output logic                  almost_empty_o,
  output logic [CNT_W-1:0]      usage_o,
  output logic                  overflow_o,
  output logic                  underflow_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  if (DEPTH < 1) begin : g_depth_check
    $error("fifo_v4: DEPTH must be at least 1");
  end

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      usage_q, usage_d;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;

  logic full, empty, bypass, push_acc, pop_acc, ovf_set, unf_set;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
    return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
  endfunction

  assign full  = (usage_q == CNT_W'(DEPTH));
  assign empty = (usage_q == '0);

  // An empty fall-through FIFO hands data_i straight to the reader; nothing is stored.
  assign bypass   = (FALL_THROUGH != 0) && empty && push_i && pop_i;
  assign push_acc = push_i && (!full || pop_i) && !bypass && !flush_i;
  assign pop_acc  = pop_i && !empty && !flush_i;
  assign ovf_set  = push_i && full && !pop_i && !flush_i;
  assign unf_set  = pop_i && empty && !bypass && !flush_i;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    usage_d     = usage_q;
    overflow_d  = (overflow_q && !clr_err_i) || ovf_set;
    underflow_d = (underflow_q && !clr_err_i) || unf_set;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      usage_d  = '0;
    end else begin
      if (push_acc) wr_ptr_d = next_ptr(wr_ptr_q);
      if (pop_acc)  rd_ptr_d = next_ptr(rd_ptr_q);
      if (push_acc && !pop_acc)      usage_d = usage_q + CNT_W'(1);
      else if (pop_acc && !push_acc) usage_d = usage_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      usage_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      usage_q     <= usage_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
      if (push_acc) mem_q[wr_ptr_q] <= data_i;
    end
  end

  always_comb begin
    if (!empty)                 data_o = mem_q[rd_ptr_q];
    else if (FALL_THROUGH != 0) data_o = data_i;
    else                        data_o = '0;
  end

  assign full_o         = full;
  assign empty_o        = empty;
  assign usage_o        = usage_q;
  assign almost_full_o  = (usage_q >= almost_full_th_i);
  assign almost_empty_o = (usage_q <= almost_empty_th_i);
  assign overflow_o     = overflow_q;
  assign underflow_o    = underflow_q;

endmodule
`default_nettype wire

// File: tb/tb_fifo_v4.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_fifo_v4 : randomized bench for fifo_v4, FT=0 and FT=1 side by side    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_fifo_v4;

  localparam int DW    = 8;
  localparam int DEPTH = 5;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          rst_ni = 1'b0;
  logic          flush_i = 1'b0, clr_err_i = 1'b0, push_i = 1'b0, pop_i = 1'b0;
  logic [DW-1:0] data_i = '0;
  logic [CW-1:0] af_th = CW'(4), ae_th = CW'(1);

  logic [DW-1:0] dout  [2];
  logic [CW-1:0] usage [2];
  logic          full [2], empty [2], afull [2], aempty [2], ovf [2], unf [2];

  // Reference: per instance an ordered list (index 0 = head) plus sticky flags.
  logic [DW-1:0] m_list [2][DEPTH];
  int            m_cnt  [2];
  logic          m_ovf  [2], m_unf [2];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  for (genvar k = 0; k < 2; k++) begin : g_dut
    fifo_v4 #(.FALL_THROUGH(k), .DATA_WIDTH(DW), .DEPTH(DEPTH)) u_dut (
      .clk_i(clk), .rst_ni(rst_ni), .flush_i(flush_i), .clr_err_i(clr_err_i),
      .almost_full_th_i(af_th), .almost_empty_th_i(ae_th),
      .data_i(data_i), .push_i(push_i), .data_o(dout[k]), .pop_i(pop_i),
      .full_o(full[k]), .empty_o(empty[k]), .almost_full_o(afull[k]),
      .almost_empty_o(aempty[k]), .usage_o(usage[k]),
      .overflow_o(ovf[k]), .underflow_o(unf[k])
    );
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_cnt[k] = 0;
      m_ovf[k] = 1'b0;
      m_unf[k] = 1'b0;
    end
  endtask

  task automatic check_outputs();
    for (int k = 0; k < 2; k++) begin
      logic [DW-1:0] exp_d;
      exp_d = (m_cnt[k] > 0) ? m_list[k][0] : ((k == 1) ? data_i : '0);
      check($sformatf("ft%0d.usage", k),  32'(usage[k]),  32'(m_cnt[k]));
      check($sformatf("ft%0d.empty", k),  32'(empty[k]),  32'(m_cnt[k] == 0));
      check($sformatf("ft%0d.full", k),   32'(full[k]),   32'(m_cnt[k] == DEPTH));
      check($sformatf("ft%0d.afull", k),  32'(afull[k]),  32'(m_cnt[k] >= int'(af_th)));
      check($sformatf("ft%0d.aempty", k), 32'(aempty[k]), 32'(m_cnt[k] <= int'(ae_th)));
      check($sformatf("ft%0d.data", k),   32'(dout[k]),   32'(exp_d));
      check($sformatf("ft%0d.ovf", k),    32'(ovf[k]),    32'(m_ovf[k]));
      check($sformatf("ft%0d.unf", k),    32'(unf[k]),    32'(m_unf[k]));
    end
  endtask

  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      logic is_empty, is_full, bypass, set_o, set_u;
      is_empty = (m_cnt[k] == 0);
      is_full  = (m_cnt[k] == DEPTH);
      bypass   = (k == 1) && is_empty && push_i && pop_i;
      set_o    = !flush_i && push_i && is_full && !pop_i;
      set_u    = !flush_i && pop_i && is_empty && !bypass;
      if (flush_i) begin
        m_cnt[k] = 0;
      end else if (!bypass) begin
        if (pop_i && !is_empty) begin
          for (int i = 0; i < DEPTH - 1; i++) m_list[k][i] = m_list[k][i+1];
          m_cnt[k]--;
        end
        if (push_i && (!is_full || pop_i)) begin
          m_list[k][m_cnt[k]] = data_i;
          m_cnt[k]++;
        end
      end
      m_ovf[k] = (m_ovf[k] && !clr_err_i) || set_o;
      m_unf[k] = (m_unf[k] && !clr_err_i) || set_u;
    end
  endtask

  task automatic cyc(input logic ps, input logic pp, input logic [DW-1:0] d,
                     input logic fl = 1'b0, input logic cl = 1'b0);
    @(negedge clk);
    push_i = ps; pop_i = pp; data_i = d; flush_i = fl; clr_err_i = cl;
    #1 check_outputs();
    @(posedge clk);
    model_step();
  endtask

  initial begin
    model_reset();
    #2 check_outputs();
    @(negedge clk) rst_ni = 1'b1;

    // Fill to full, then drain in order
    for (int i = 1; i <= 5; i++) cyc(1'b1, 1'b0, DW'(i * 8'h11));
    cyc(1'b0, 1'b0, '0);
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1, '0);
    cyc(1'b0, 1'b0, '0);

    // Full with simultaneous push/pop, then alternate to force pointer wrap
    for (int i = 1; i <= 5; i++) cyc(1'b1, 1'b0, DW'(i * 8'h11));
    cyc(1'b1, 1'b1, 8'h66);
    for (int i = 0; i < 7; i++) cyc(i[0], !i[0], DW'(8'h70 + i));
    cyc(1'b0, 1'b0, '0);

    // Overflow, sticky, cleared, then underflow
    cyc(1'b1, 1'b0, 8'h77);
    cyc(1'b1, 1'b0, 8'h78);
    cyc(1'b0, 1'b0, '0);
    cyc(1'b0, 1'b0, '0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, '0, 1'b1);
    cyc(1'b0, 1'b1, '0);
    cyc(1'b0, 1'b0, '0, 1'b0, 1'b1);

    // Empty push+pop: fall-through on one instance, underflow on the other
    cyc(1'b1, 1'b1, 8'hAB);
    cyc(1'b0, 1'b0, 8'h3C);
    cyc(1'b0, 1'b0, '0, 1'b1, 1'b1);

    // Thresholds and flush beating a push
    af_th = CW'(4); ae_th = CW'(1);
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, DW'(8'hC0 + i));
    cyc(1'b1, 1'b0, 8'hEE, 1'b1);
    cyc(1'b0, 1'b0, '0);

    // Async reset mid-burst at usage 3
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, DW'(8'hD0 + i));
    @(negedge clk);
    push_i = 1'b0; pop_i = 1'b0; data_i = 8'h5A;
    #2 rst_ni = 1'b0;
    model_reset();
    #1 check_outputs();
    @(negedge clk) rst_ni = 1'b1;
    cyc(1'b1, 1'b0, 8'h99);
    cyc(1'b0, 1'b0, '0);

    // Randomized traffic with occasional flush, clear and threshold changes
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 15) == 0) begin
        af_th = CW'($urandom_range(0, 7));
        ae_th = CW'($urandom_range(0, 7));
      end
      cyc(($urandom_range(0, 99) < 55), ($urandom_range(0, 99) < 45), DW'($urandom),
          ($urandom_range(0, 29) == 0), ($urandom_range(0, 9) == 0));
    end
    cyc(1'b0, 1'b0, '0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
